// File: rtl/instr_encoder_loader_pkg.sv
// Shared encoding constants for the program loader: request op codes, MIPS opcodes/functs,
// FSM state type and small word-packing helpers.
package instr_encoder_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FULL = 2'd2
    } state_t;

    // Symbolic request codes carried on in_op; codes 11..15 are illegal.
    localparam logic [3:0] OP_ADDU    = 4'd0;
    localparam logic [3:0] OP_SUBU    = 4'd1;
    localparam logic [3:0] OP_JR      = 4'd2;
    localparam logic [3:0] OP_SYSCALL = 4'd3;
    localparam logic [3:0] OP_ORI     = 4'd4;
    localparam logic [3:0] OP_LW      = 4'd5;
    localparam logic [3:0] OP_SW      = 4'd6;
    localparam logic [3:0] OP_BEQ     = 4'd7;
    localparam logic [3:0] OP_LUI     = 4'd8;
    localparam logic [3:0] OP_JAL     = 4'd9;
    localparam logic [3:0] OP_J       = 4'd10;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_J     = 6'h02;
    localparam logic [5:0] OPC_JAL   = 6'h03;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_LUI   = 6'h0F;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;

    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_SYSCALL = 6'h0C;
    localparam logic [5:0] FN_ADDU    = 6'h21;
    localparam logic [5:0] FN_SUBU    = 6'h23;

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {OPC_RTYPE, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] opc, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {opc, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] opc, input logic [25:0] target);
        return {opc, target};
    endfunction

endpackage

// File: rtl/instr_encoder_loader_if.sv
// Request and instruction-memory write bundle for the program loader.
// Request side: a word moves when in_valid && in_ready on a rising edge; the requester holds
// its fields stable until then. Write side: imem_we/addr/wdata hold until imem_ready is seen.
interface instr_encoder_loader_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_op;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [15:0]       in_imm;
    logic [25:0]       in_target;
    logic              imem_we;
    logic              imem_ready;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport slave (
        input  in_valid, in_op, in_rs, in_rt, in_rd, in_imm, in_target, imem_ready,
        output in_ready, imem_we, imem_addr, imem_wdata
    );

    modport master (
        output in_valid, in_op, in_rs, in_rt, in_rd, in_imm, in_target, imem_ready,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/instr_encoder_loader_field_pack.sv
// Combinational field packer: turns a symbolic request into a 32-bit MIPS word plus a legal flag.
module instr_encoder_loader_field_pack
    import instr_encoder_loader_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        legal
);

    // Fields an op does not use are simply never routed, which masks them to zero.
    always_comb begin
        word  = 32'd0;
        legal = 1'b1;
        case (op)
            OP_ADDU:    word = enc_r(rs, rt, rd, FN_ADDU);
            OP_SUBU:    word = enc_r(rs, rt, rd, FN_SUBU);
            OP_JR:      word = enc_r(rs, 5'd0, 5'd0, FN_JR);
            OP_SYSCALL: word = enc_r(5'd0, 5'd0, 5'd0, FN_SYSCALL);
            OP_ORI:     word = enc_i(OPC_ORI, rs, rt, imm);
            OP_LW:      word = enc_i(OPC_LW, rs, rt, imm);
            OP_SW:      word = enc_i(OPC_SW, rs, rt, imm);
            OP_BEQ:     word = enc_i(OPC_BEQ, rs, rt, imm);
            OP_LUI:     word = enc_i(OPC_LUI, 5'd0, rt, imm);
            OP_JAL:     word = enc_j(OPC_JAL, target);
            OP_J:       word = enc_j(OPC_J, target);
            default:    legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: accepts symbolic requests, encodes them, and writes them to consecutive
// imem word addresses starting at 0 after each start pulse.
module instr_encoder_loader
    import instr_encoder_loader_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    instr_encoder_loader_if.slave  bus,
    output logic                   done,
    output logic                   err,
    output logic [ADDR_W:0]        count,
    output state_t                 state_dbg
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [31:0]       word;
    logic              legal;
    logic              accept;
    logic              write_done;
    logic              start_ok;

    instr_encoder_loader_field_pack u_pack (
        .op     (bus.in_op),
        .rs     (bus.in_rs),
        .rt     (bus.in_rt),
        .rd     (bus.in_rd),
        .imm    (bus.in_imm),
        .target (bus.in_target),
        .word   (word),
        .legal  (legal)
    );

    // A new request may enter whenever the output register is empty or emptying this cycle.
    assign bus.in_ready = (state == ST_RUN) && (!bus.imem_we || bus.imem_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign write_done   = bus.imem_we && bus.imem_ready;
    assign start_ok     = start && (state != ST_RUN);
    assign state_dbg    = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            done           <= 1'b0;
            err            <= 1'b0;
            ptr            <= '0;
            count          <= '0;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= 32'd0;
        end else begin
            case (state)
                ST_IDLE, ST_FULL: begin
                    if (start) begin
                        state <= ST_RUN;
                        done  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // Only a legal word landing in the last slot closes the pass.
                    if (accept && legal && (ptr == LAST_ADDR)) begin
                        state <= ST_FULL;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                end
            endcase

            if (start_ok) begin
                ptr <= '0;
                err <= 1'b0;
            end else if (accept) begin
                if (legal) ptr <= ptr + 1'b1;
                else       err <= 1'b1;
            end

            if (start_ok)        count <= '0;
            else if (write_done) count <= count + 1'b1;

            // A write still pending across a restart keeps its original address and data.
            if (accept && legal) begin
                bus.imem_we    <= 1'b1;
                bus.imem_addr  <= ptr;
                bus.imem_wdata <= word;
            end else if (write_done) begin
                bus.imem_we    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for the program loader (DEPTH=4): encodings, stalls, illegal ops, full/restart, reset.
module tb_instr_encoder_loader;
    import instr_encoder_loader_pkg::*;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;
    localparam int W      = ADDR_W + 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic            done;
    logic            err;
    logic [ADDR_W:0] count;
    state_t          state_dbg;

    int n_vec = 0;
    int n_mis = 0;
    logic [W-1:0] exp_q[$];

    instr_encoder_loader_if #(.ADDR_W(ADDR_W)) bus ();

    instr_encoder_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bus       (bus),
        .done      (done),
        .err       (err),
        .count     (count),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic set_req(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt);
        bus.in_op     = op;
        bus.in_rs     = rs;
        bus.in_rt     = rt;
        bus.in_rd     = rd;
        bus.in_imm    = imm;
        bus.in_target = tgt;
    endtask

    // Present one request, wait (bounded) for acceptance, then check the cycle-after outputs.
    task automatic send(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt,
                        input logic [ADDR_W-1:0] ea, input logic [31:0] ew, input bit legal);
        int waited = 0;
        set_req(op, rs, rt, rd, imm, tgt);
        bus.in_valid = 1'b1;
        #1;
        while (!bus.in_ready && waited < 50) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!bus.in_ready) begin
            n_vec++;
            n_mis++;
            $error("FAIL accept_timeout: in_ready observed 0 expected 1 (op %0d)", op);
            bus.in_valid = 1'b0;
            return;
        end
        if (legal) exp_q.push_back({ea, ew});
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        if (legal) begin
            check("lat_we", bus.imem_we, 1);
            check("lat_addr", bus.imem_addr, ea);
            check("lat_wdata", bus.imem_wdata, ew);
        end else begin
            check("illegal_no_we", bus.imem_we, 0);
            check("illegal_err", err, 1);
        end
    endtask

    // Scoreboard: every completed imem write must match the next expected {addr, data}.
    always @(negedge clk) begin
        if (rst_n && bus.imem_we && bus.imem_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_mis++;
                $error("FAIL unexpected_write: observed addr %0d data 0x%08h expected no write",
                       bus.imem_addr, bus.imem_wdata);
            end else begin
                check("write", {bus.imem_addr, bus.imem_wdata}, exp_q.pop_front());
            end
        end
    end

    initial begin
        rst_n          = 1'b0;
        start          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.imem_ready = 1'b0;
        set_req(4'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
        repeat (3) tick();

        check("rst_in_ready", bus.in_ready, 0);
        check("rst_we", bus.imem_we, 0);
        check("rst_addr", bus.imem_addr, 0);
        check("rst_wdata", bus.imem_wdata, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_count", count, 0);
        check("rst_state", 64'(state_dbg), 64'(ST_IDLE));

        // Nothing is consumed before the first start.
        rst_n = 1'b1;
        set_req(OP_ADDU, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0);
        bus.in_valid = 1'b1;
        tick();
        tick();
        check("idle_no_ready", bus.in_ready, 0);
        check("idle_state", 64'(state_dbg), 64'(ST_IDLE));
        bus.in_valid   = 1'b0;
        bus.imem_ready = 1'b1;

        // Pass 1: encodings, illegal op, fill to FULL.
        pulse_start();
        check("p1_state_run", 64'(state_dbg), 64'(ST_RUN));
        check("p1_in_ready", bus.in_ready, 1);
        send(OP_ADDU, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 2'd0, 32'h00221821, 1'b1);
        send(OP_ORI, 5'd0, 5'd8, 5'd0, 16'h1234, 26'd0, 2'd1, 32'h34081234, 1'b1);
        send(4'd15, 5'd7, 5'd7, 5'd7, 16'hFFFF, 26'h3FFFFFF, 2'd0, 32'd0, 1'b0);
        send(OP_LW, 5'd29, 5'd9, 5'd0, 16'hFFFC, 26'd0, 2'd2, 32'h8FA9FFFC, 1'b1);
        send(OP_JAL, 5'd0, 5'd0, 5'd0, 16'd0, 26'h0100000, 2'd3, 32'h0C100000, 1'b1);
        check("p1_done", done, 1);
        check("p1_state_full", 64'(state_dbg), 64'(ST_FULL));

        // A fifth request is held off while FULL.
        set_req(OP_SYSCALL, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
        bus.in_valid = 1'b1;
        repeat (5) tick();
        check("full_in_ready", bus.in_ready, 0);
        check("full_count", count, 4);
        check("full_err_sticky", err, 1);
        check("full_we_idle", bus.imem_we, 0);
        bus.in_valid = 1'b0;

        // Pass 2: output stage held during an imem stall.
        pulse_start();
        check("p2_err_clr", err, 0);
        check("p2_count_clr", count, 0);
        check("p2_done_clr", done, 0);
        bus.imem_ready = 1'b0;
        send(OP_SYSCALL, 5'd3, 5'd4, 5'd5, 16'h0001, 26'h0000001, 2'd0, 32'h0000000C, 1'b1);
        set_req(OP_JR, 5'd31, 5'd5, 5'd6, 16'd0, 26'd0);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_in_ready", bus.in_ready, 0);
            check("stall_we", bus.imem_we, 1);
            check("stall_addr", bus.imem_addr, 0);
            check("stall_wdata", bus.imem_wdata, 32'h0000000C);
        end
        bus.imem_ready = 1'b1;
        send(OP_JR, 5'd31, 5'd5, 5'd6, 16'd0, 26'd0, 2'd1, 32'h03E00008, 1'b1);
        check("p2_count1", count, 1);
        send(OP_SUBU, 5'd4, 5'd5, 5'd6, 16'd0, 26'd0, 2'd2, 32'h00853023, 1'b1);
        send(OP_SW, 5'd29, 5'd10, 5'd0, 16'h0008, 26'd0, 2'd3, 32'hAFAA0008, 1'b1);
        tick();
        check("p2_count4", count, 4);
        check("p2_done", done, 1);

        // Pass 3: restart count, then asynchronous reset during a stalled write.
        pulse_start();
        send(OP_LUI, 5'd7, 5'd1, 5'd0, 16'hABCD, 26'd0, 2'd0, 32'h3C01ABCD, 1'b1);
        tick();
        check("p3_count1", count, 1);
        bus.imem_ready = 1'b0;
        send(OP_BEQ, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'd0, 2'd1, 32'h1022FFFF, 1'b1);
        tick();
        check("p3_we_held", bus.imem_we, 1);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_we", bus.imem_we, 0);
        check("mid_rst_addr", bus.imem_addr, 0);
        check("mid_rst_wdata", bus.imem_wdata, 0);
        check("mid_rst_count", count, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_in_ready", bus.in_ready, 0);
        check("mid_rst_state", 64'(state_dbg), 64'(ST_IDLE));
        tick();
        rst_n          = 1'b1;
        bus.imem_ready = 1'b1;
        set_req(OP_J, 5'd0, 5'd0, 5'd0, 16'd0, 26'h3FFFFFF);
        bus.in_valid = 1'b1;
        repeat (3) tick();
        check("post_rst_in_ready", bus.in_ready, 0);
        check("post_rst_we", bus.imem_we, 0);
        bus.in_valid = 1'b0;

        // Pass 4: masking of unused fields, restart while the final write is pending.
        pulse_start();
        send(OP_J, 5'd9, 5'd9, 5'd9, 16'hFFFF, 26'h3FFFFFF, 2'd0, 32'h0BFFFFFF, 1'b1);
        send(OP_ORI, 5'd0, 5'd8, 5'd31, 16'h1234, 26'h2AAAAAA, 2'd1, 32'h34081234, 1'b1);
        send(OP_JR, 5'd31, 5'd5, 5'd6, 16'hFFFF, 26'h3FFFFFF, 2'd2, 32'h03E00008, 1'b1);
        tick();
        bus.imem_ready = 1'b0;
        send(OP_BEQ, 5'd1, 5'd2, 5'd17, 16'hFFFF, 26'd0, 2'd3, 32'h1022FFFF, 1'b1);
        check("p4_done", done, 1);
        pulse_start();
        check("restart_state", 64'(state_dbg), 64'(ST_RUN));
        check("restart_we_pending", bus.imem_we, 1);
        check("restart_addr_kept", bus.imem_addr, 3);
        check("restart_in_ready", bus.in_ready, 0);
        bus.imem_ready = 1'b1;
        send(OP_ADDU, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 2'd0, 32'h00221821, 1'b1);
        tick();
        check("final_we_drop", bus.imem_we, 0);
        check("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
